spike_rate_decoder: RTL and testbench

//  Rate decoder: the inverse of the LFSR spike encoder. Counts spikes on one spike line over a

---
 rtl/spike_rate_decoder_pkg.sv | 33 +++
 rtl/spike_rate_decoder_rate_classifier.sv | 55 +++++
 rtl/spike_rate_decoder.sv | 130 +++++++++++++
 tb/tb_spike_rate_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/spike_rate_decoder_pkg.sv
// Shared definitions for the spike rate decoder.
// Holds the FSM state encoding and the class/frequency/threshold constants
// that mirror the LFSR spike encoder's probability bands.
package spike_rate_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Probability classes: spike probability is 2^-class.
  localparam logic [3:0] CLASS_NONE = 4'd0;
  localparam logic [3:0] CLASS_5    = 4'd5;
  localparam logic [3:0] CLASS_6    = 4'd6;
  localparam logic [3:0] CLASS_7    = 4'd7;
  localparam logic [3:0] CLASS_8    = 4'd8;

  // rf_freq_buffer band midpoints for each class.
  localparam logic [7:0] FREQ_NONE = 8'd0;
  localparam logic [7:0] FREQ_5    = 8'd36;
  localparam logic [7:0] FREQ_6    = 8'd72;
  localparam logic [7:0] FREQ_7    = 8'd144;
  localparam logic [7:0] FREQ_8    = 8'd224;

  // Band edges sit at 3/2^k: compare c*2^k against 3*N.
  localparam int THRESH_MULT = 3;
  localparam int SHIFT_OVR   = 6;
  localparam int SHIFT_C5    = 7;
  localparam int SHIFT_C6    = 8;
  localparam int SHIFT_C7    = 9;

endpackage

// File: rtl/spike_rate_decoder_rate_classifier.sv
// Combinational rate classifier.
// Maps a spike count c over a window of N timesteps onto the encoder's
// probability class and a representative 8-bit frequency code.
// Ports:
//   count      in  CNT_W  spikes seen in the window
//   n_len      in  LEN_W  window length N
//   prob_class out 4      0, 5, 6, 7 or 8
//   freq_code  out 8      band midpoint for the class
//   overrange  out 1      rate above the class-5 band
module rate_classifier
  import spike_rate_decoder_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] count,
  input  logic [LEN_W-1:0] n_len,
  output logic [3:0]       prob_class,
  output logic [7:0]       freq_code,
  output logic             overrange
);

  // Common width large enough for both c*512 and 3*N, so no product truncates.
  localparam int PW = ((CNT_W + 9) > (LEN_W + 2)) ? (CNT_W + 9) : (LEN_W + 2);

  logic [PW-1:0] c_ext;
  logic [PW-1:0] n3;

  assign c_ext = PW'(count);
  assign n3    = PW'(n_len) * PW'(THRESH_MULT);

  always_comb begin
    prob_class = CLASS_NONE;
    freq_code  = FREQ_NONE;
    overrange  = 1'b0;
    if (count == '0) begin
      prob_class = CLASS_NONE;
    end else if ((c_ext << SHIFT_OVR) >= n3) begin
      overrange = 1'b1;
    end else if ((c_ext << SHIFT_C5) >= n3) begin
      prob_class = CLASS_5;
      freq_code  = FREQ_5;
    end else if ((c_ext << SHIFT_C6) >= n3) begin
      prob_class = CLASS_6;
      freq_code  = FREQ_6;
    end else if ((c_ext << SHIFT_C7) >= n3) begin
      prob_class = CLASS_7;
      freq_code  = FREQ_7;
    end else begin
      prob_class = CLASS_8;
      freq_code  = FREQ_8;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: inverse of the LFSR spike encoder.
// Counts spikes on one line over a window of N timesteps and reports the
// decoded probability class and frequency code through a valid/ready handshake.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   window_start  begin a measurement (only honoured in IDLE)
//   window_len    window length N, sampled with an accepted start
//   spike_strobe  timestep tick; spike_in counted only on a tick
//   spike_in      spike line
//   busy          high while counting
//   result_valid  result fields valid, held until result_ready
//   result_ready  consumer accepts the result
//   spike_count, prob_class, freq_code, overrange  last result
module spike_rate_decoder
  import spike_rate_decoder_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             window_start,
  input  logic [LEN_W-1:0] window_len,
  input  logic             spike_strobe,
  input  logic             spike_in,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] spike_count,
  output logic [3:0]       prob_class,
  output logic [7:0]       freq_code,
  output logic             overrange
);

  state_t           state;
  logic [LEN_W-1:0] n_len_q;
  logic [LEN_W-1:0] ts_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CNT_W-1:0] cnt_next;
  logic             last_strobe;
  logic [3:0]       cls_next;
  logic [7:0]       freq_next;
  logic             ovr_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign cnt_next    = spike_in ? sat_inc(cnt_q) : cnt_q;
  // N >= 1 whenever COUNT is entered, so n_len_q - 1 never underflows here.
  assign last_strobe = spike_strobe && (ts_q == n_len_q - LEN_W'(1));

  // Classify the count including the final strobe's spike, so the result
  // can be registered on the same edge that enters DONE.
  rate_classifier #(
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) u_classifier (
    .count      (cnt_next),
    .n_len      (n_len_q),
    .prob_class (cls_next),
    .freq_code  (freq_next),
    .overrange  (ovr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      n_len_q      <= '0;
      ts_q         <= '0;
      cnt_q        <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      spike_count  <= '0;
      prob_class   <= CLASS_NONE;
      freq_code    <= FREQ_NONE;
      overrange    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (window_start) begin
            n_len_q <= window_len;
            ts_q    <= '0;
            cnt_q   <= '0;
            if (window_len == '0) begin
              // Empty window: report a zero result straight away.
              state        <= ST_DONE;
              result_valid <= 1'b1;
              spike_count  <= '0;
              prob_class   <= CLASS_NONE;
              freq_code    <= FREQ_NONE;
              overrange    <= 1'b0;
            end else begin
              state <= ST_COUNT;
              busy  <= 1'b1;
            end
          end
        end
        ST_COUNT: begin
          if (spike_strobe) begin
            ts_q  <= ts_q + LEN_W'(1);
            cnt_q <= cnt_next;
            if (last_strobe) begin
              state        <= ST_DONE;
              busy         <= 1'b0;
              result_valid <= 1'b1;
              spike_count  <= cnt_next;
              prob_class   <= cls_next;
              freq_code    <= freq_next;
              overrange    <= ovr_next;
            end
          end
        end
        ST_DONE: begin
          if (result_ready) begin
            state        <= ST_IDLE;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: table-driven windows with a scoreboard,
// plus hand-written sequences for handshake hold, reset abort and loopback.
module tb_spike_rate_decoder;

  localparam int LEN_W = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             window_start;
  logic [LEN_W-1:0] window_len;
  logic             spike_strobe;
  logic             spike_in;
  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic [CNT_W-1:0] spike_count;
  logic [3:0]       prob_class;
  logic [7:0]       freq_code;
  logic             overrange;

  always #5 clk = ~clk;

  spike_rate_decoder #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .window_start (window_start),
    .window_len   (window_len),
    .spike_strobe (spike_strobe),
    .spike_in     (spike_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .spike_count  (spike_count),
    .prob_class   (prob_class),
    .freq_code    (freq_code),
    .overrange    (overrange)
  );

  typedef struct {
    int cnt;
    int cls;
    int freq;
    int ovr;
  } exp_t;

  // period > 0: spike on every period-th strobe starting at strobe 0
  // period = 0: no spikes; period < 0: random spikes at ~1/128
  // e.cnt < 0: expected result taken from the reference model
  typedef struct {
    int   n;
    int   period;
    exp_t e;
  } vec_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   spk_arr[];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic exp_t model(input longint c, input longint n);
    exp_t e;
    e = '{cnt: int'(c), cls: 0, freq: 0, ovr: 0};
    if (c == 0)                e.cls = 0;
    else if (c * 64  >= 3 * n) e.ovr = 1;
    else if (c * 128 >= 3 * n) begin e.cls = 5; e.freq = 36;  end
    else if (c * 256 >= 3 * n) begin e.cls = 6; e.freq = 72;  end
    else if (c * 512 >= 3 * n) begin e.cls = 7; e.freq = 144; end
    else                       begin e.cls = 8; e.freq = 224; end
    return e;
  endfunction

  task automatic check_result(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_count"}, int'(spike_count), e.cnt);
      chk({tag, "_class"}, int'(prob_class), e.cls);
      chk({tag, "_freq"},  int'(freq_code), e.freq);
      chk({tag, "_ovr"},   int'(overrange), e.ovr);
    end
  endtask

  task automatic run_window(input vec_t v, input bit do_ack, input string tag);
    int   nsp = 0;
    int   k = 0;
    exp_t e;
    spk_arr = new[(v.n > 0) ? v.n : 1];
    for (int i = 0; i < v.n; i++) begin
      if (v.period > 0)      spk_arr[i] = (i % v.period == 0);
      else if (v.period < 0) spk_arr[i] = ($urandom_range(0, 255) < 2);
      else                   spk_arr[i] = 1'b0;
      nsp += int'(spk_arr[i]);
    end
    e = (v.e.cnt >= 0) ? v.e : model(nsp, v.n);
    sb_q.push_back(e);

    window_len   = LEN_W'(v.n);
    window_start = 1'b1;
    @(posedge clk); #1;
    window_start = 1'b0;
    if (v.n > 0) begin
      chk({tag, "_busy_start"}, int'(busy), 1);
      for (int i = 0; i < v.n; i++) begin
        // Short windows get idle cycles with stray spikes that must be ignored.
        if (v.n <= 1024) begin
          repeat ($urandom_range(0, 1)) begin
            spike_in = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
          end
        end
        spike_strobe = 1'b1;
        spike_in     = spk_arr[i];
        @(posedge clk); #1;
        spike_strobe = 1'b0;
        spike_in     = 1'b0;
      end
    end
    while (!result_valid && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_valid_wait"}, k, 0);
    chk({tag, "_busy_done"}, int'(busy), 0);
    check_result(tag);
    if (do_ack) begin
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      chk({tag, "_valid_clear"}, int'(result_valid), 0);
    end
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{n: 256, period: 32,  e: '{8, 5, 36, 0}};
    vecs[1] = '{n: 256, period: 64,  e: '{4, 6, 72, 0}};
    vecs[2] = '{n: 256, period: 256, e: '{1, 8, 224, 0}};
    vecs[3] = '{n: 256, period: 0,   e: '{0, 0, 0, 0}};
    vecs[4] = '{n: 256, period: 13,  e: '{20, 0, 0, 1}};
    vecs[5] = '{n: 0,   period: 0,   e: '{0, 0, 0, 0}};
    vecs[6] = '{n: 1,   period: 1,   e: '{1, 0, 0, 1}};
    vecs[7] = '{n: 128, period: 43,  e: '{3, 5, 36, 0}};   // c*128 == 3N edge
    vecs[8] = '{n: 64,  period: 22,  e: '{3, 0, 0, 1}};    // c*64 == 3N edge
    vecs[9] = '{n: 100, period: 50,  e: '{2, 6, 72, 0}};

    rst          = 1'b1;
    window_start = 1'b0;
    window_len   = '0;
    spike_strobe = 1'b0;
    spike_in     = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  int'(busy), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_count", int'(spike_count), 0);
    chk("rst_class", int'(prob_class), 0);
    chk("rst_freq",  int'(freq_code), 0);
    chk("rst_ovr",   int'(overrange), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_window(vecs[i], 1'b1, $sformatf("vec%0d", i));
    end

    // Hold result_ready low: result must stay put, extra starts ignored.
    run_window('{n: 256, period: 64, e: '{4, 6, 72, 0}}, 1'b0, "hold");
    for (int i = 0; i < 10; i++) begin
      window_start = 1'b1;
      window_len   = LEN_W'(5);
      spike_strobe = 1'b1;
      spike_in     = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", int'(result_valid), 1);
      chk("hold_count", int'(spike_count), 4);
      chk("hold_class", int'(prob_class), 6);
      chk("hold_busy",  int'(busy), 0);
    end
    window_start = 1'b0;
    spike_strobe = 1'b0;
    spike_in     = 1'b0;
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk("hold_release_valid", int'(result_valid), 0);
    @(posedge clk); #1;
    chk("hold_no_restart", int'(busy), 0);

    // Asynchronous reset at strobe 100 of a 256-step window.
    window_len   = LEN_W'(256);
    window_start = 1'b1;
    @(posedge clk); #1;
    window_start = 1'b0;
    for (int i = 0; i < 99; i++) begin
      spike_strobe = 1'b1;
      spike_in     = (i % 10 == 0);
      @(posedge clk); #1;
    end
    spike_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("abort_busy",  int'(busy), 0);
    chk("abort_valid", int'(result_valid), 0);
    chk("abort_count", int'(spike_count), 0);
    chk("abort_class", int'(prob_class), 0);
    chk("abort_freq",  int'(freq_code), 0);
    chk("abort_ovr",   int'(overrange), 0);
    @(posedge clk); #1;
    spike_strobe = 1'b0;
    spike_in     = 1'b0;
    rst          = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle_valid", int'(result_valid), 0);
    run_window('{n: 256, period: 32, e: '{8, 5, 36, 0}}, 1'b1, "after_rst");

    // Encoder-like loopback over the maximum window.
    run_window('{n: 65535, period: -1, e: '{-1, 0, 0, 0}}, 1'b1, "loopback");

    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
